// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch -> execute -> commit (PC+4 / branch / trap) with a defined exit
// from every state encoding. Define FETCH_TIMEOUT_EN to add a fetch-wait watchdog that traps with cause 10.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0100,
    parameter logic [31:0] HALT_ADDR      = 32'h0000_004C,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] pc,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        pc_en,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic        halted,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state
);
    // state  | meaning
    // IDLE   | waiting for start
    // FETCH  | fetch request at pc, or halt if pc is HALT_ADDR
    // EXEC   | waiting for execute completion, capture branch result
    // UPDATE | load pc with PC+4 or branch target
    // TRAP   | load pc with TRAP_VECTOR, pulse trap
    // HALT   | absorbing until reset
    // 6, 7   | illegal, outputs quiet, return to IDLE
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_TRAP   = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    if (TRAP_VECTOR[1:0] != 2'b00) begin : g_trap_vector_check
        $error("pc_sequencer: TRAP_VECTOR must be word aligned");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_check
        $error("pc_sequencer: TIMEOUT_CYCLES must be within 2..255");
    end

    logic [2:0]  state_q, state_d;
    logic        taken_q;
    logic [31:0] target_q;
    logic [1:0]  cause_q;
    logic        at_halt, misaligned, timeout_hit;

    assign at_halt    = (pc == HALT_ADDR);
    assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;

    // Held at zero outside FETCH, so every FETCH visit starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 8'd0;
        end else if (state_q != S_FETCH) begin
            tmo_cnt_q <= 8'd0;
        end else if (!fetch_ack) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end

    assign timeout_hit = (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = start ? S_FETCH : S_IDLE;
            S_FETCH: begin
                if (at_halt)          state_d = S_HALT;
                else if (fetch_ack)   state_d = S_EXEC;
                else if (timeout_hit) state_d = S_TRAP;
                else                  state_d = S_FETCH;
            end
            S_EXEC: begin
                if (exec_done) state_d = misaligned ? S_TRAP : S_UPDATE;
                else           state_d = S_EXEC;
            end
            S_UPDATE: state_d = S_FETCH;
            S_TRAP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q  <= 1'b0;
            target_q <= 32'h0;
            cause_q  <= 2'b00;
        end else begin
            if (state_q == S_EXEC && exec_done) begin
                taken_q  <= branch_taken;
                target_q <= branch_target;
                if (misaligned) cause_q <= 2'b01;
            end
            if (state_q == S_FETCH && !at_halt && !fetch_ack && timeout_hit) begin
                cause_q <= 2'b10;
            end
        end
    end

    always_comb begin
        fetch_req  = 1'b0;
        fetch_addr = 32'h0;
        pc_en      = 1'b0;
        pc_src     = 1'b0;
        pc_target  = 32'h0;
        halted     = 1'b0;
        trap       = 1'b0;
        trap_cause = 2'b00;
        case (state_q)
            S_IDLE: begin
                pc_target  = target_q;
                trap_cause = cause_q;
            end
            S_FETCH: begin
                fetch_req  = !at_halt;
                fetch_addr = at_halt ? 32'h0 : pc;
                pc_target  = target_q;
                trap_cause = cause_q;
            end
            S_EXEC: begin
                pc_target  = target_q;
                trap_cause = cause_q;
            end
            S_UPDATE: begin
                pc_en      = 1'b1;
                pc_src     = taken_q;
                pc_target  = target_q;
                trap_cause = cause_q;
            end
            S_TRAP: begin
                pc_en      = 1'b1;
                pc_src     = 1'b1;
                pc_target  = TRAP_VECTOR;
                trap       = 1'b1;
                trap_cause = cause_q;
            end
            S_HALT: begin
                halted     = 1'b1;
                pc_target  = target_q;
                trap_cause = cause_q;
            end
            default: ;
        endcase
    end

    assign state = state_q;

`ifndef SYNTHESIS
    logic first_fetch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fetch_q <= 1'b1;
        end else if (state_q == S_FETCH) begin
            first_fetch_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && first_fetch_q && state_q == S_FETCH) begin
            assert (pc == RESET_VECTOR)
            else $error("pc_sequencer: first fetch after reset is not at RESET_VECTOR");
        end
    end
`endif
endmodule
